// File: rtl/uart_cmd_parser.sv
// Line-oriented command interpreter between the UART RX and TX FIFOs.
// "Waadd"/"Raa" + CR drive an 8-bit register bus; replies are "OK", "ER" or two hex digits.
module uart_cmd_parser #(
  parameter bit RESP_CRLF = 1'b1
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       rx_fifo_empty_i,
  input  logic [7:0] rx_fifo_data_out_i,
  output logic       rx_fifo_read_en_o,
  input  logic       tx_fifo_full_i,
  output logic [7:0] tx_fifo_data_in_o,
  output logic       tx_fifo_write_en_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_en_o,
  output logic       reg_rd_en_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  typedef enum logic [2:0] {FETCH, SETTLE, EXEC, RDWAIT, RESP} state_e;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [1:0] LAST_IDX = RESP_CRLF ? 2'd3 : 2'd2;

  function automatic logic is_hex(input logic [7:0] c);
    is_hex = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
             (c >= 8'h61 && c <= 8'h66);
  endfunction

  // Letters share the low nibble pattern 1..6 in both cases, so +9 covers A-F and a-f.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (c <= 8'h39) hex_val = c[3:0];
    else            hex_val = c[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] n);
    if (n < 4'd10) to_ascii = 8'h30 + {4'd0, n};
    else           to_ascii = 8'h37 + {4'd0, n};
  endfunction

  state_e     state_q;
  logic [7:0] byte_q;
  logic [7:0] line_q [5];
  logic [2:0] cnt_q;
  logic [7:0] resp_q [4];
  logic [1:0] idx_q;
  logic       rd_pend_q;
  logic       rx_rd_q, tx_we_q, wr_q, rd_q, busy_q;
  logic [7:0] tx_data_q, addr_q, wdata_q;

  logic       wr_ok_d, rd_ok_d;
  logic [7:0] addr_d, wdata_d, tx_byte_d;

  // Decode the buffered line and pick the next response byte.
  always_comb begin
    addr_d  = {hex_val(line_q[1]), hex_val(line_q[2])};
    wdata_d = {hex_val(line_q[3]), hex_val(line_q[4])};
    wr_ok_d = (cnt_q == 3'd5) && (line_q[0] == 8'h57 || line_q[0] == 8'h77) &&
              is_hex(line_q[1]) && is_hex(line_q[2]) && is_hex(line_q[3]) && is_hex(line_q[4]);
    rd_ok_d = (cnt_q == 3'd3) && (line_q[0] == 8'h52 || line_q[0] == 8'h72) &&
              is_hex(line_q[1]) && is_hex(line_q[2]);
    if (rd_pend_q) tx_byte_d = to_ascii(reg_rdata_i[7:4]);
    else           tx_byte_d = resp_q[idx_q];
  end

  // Parser FSM; every strobe is a register that self-clears after one cycle.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q   <= FETCH;
      byte_q    <= 8'h00;
      for (int i = 0; i < 5; i++) line_q[i] <= 8'h00;
      for (int i = 0; i < 4; i++) resp_q[i] <= 8'h00;
      cnt_q     <= 3'd0;
      idx_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      rx_rd_q   <= 1'b0;
      tx_we_q   <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      tx_data_q <= 8'h00;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      rx_rd_q <= 1'b0;
      tx_we_q <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      case (state_q)
        FETCH: begin
          if (!rx_fifo_empty_i) begin
            byte_q  <= rx_fifo_data_out_i;
            rx_rd_q <= 1'b1;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (byte_q == CR) begin
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else if (byte_q == LF) begin
            state_q <= FETCH;
          end else begin
            // Count saturates at 6 to remember an overflow until CR.
            if (cnt_q < 3'd5) line_q[cnt_q] <= byte_q;
            if (cnt_q != 3'd6) cnt_q <= cnt_q + 3'd1;
            state_q <= FETCH;
          end
        end
        EXEC: begin
          resp_q[2] <= CR;
          resp_q[3] <= LF;
          idx_q     <= 2'd0;
          if (wr_ok_d) begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= 1'b1;
            resp_q[0] <= 8'h4F;
            resp_q[1] <= 8'h4B;
            state_q   <= RESP;
          end else if (rd_ok_d) begin
            addr_q    <= addr_d;
            rd_q      <= 1'b1;
            rd_pend_q <= 1'b1;
            state_q   <= RDWAIT;
          end else begin
            resp_q[0] <= 8'h45;
            resp_q[1] <= 8'h52;
            state_q   <= RESP;
          end
        end
        RDWAIT: state_q <= RESP;
        RESP: begin
          // Read data is valid only in the first RESP cycle; capture both digits then.
          if (rd_pend_q) begin
            resp_q[0] <= to_ascii(reg_rdata_i[7:4]);
            resp_q[1] <= to_ascii(reg_rdata_i[3:0]);
            rd_pend_q <= 1'b0;
          end
          if (!tx_fifo_full_i) begin
            tx_data_q <= tx_byte_d;
            tx_we_q   <= 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_q   <= 2'd0;
              cnt_q   <= 3'd0;
              for (int i = 0; i < 5; i++) line_q[i] <= 8'h00;
              busy_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign rx_fifo_read_en_o  = rx_rd_q;
  assign tx_fifo_data_in_o  = tx_data_q;
  assign tx_fifo_write_en_o = tx_we_q;
  assign reg_addr_o         = addr_q;
  assign reg_wdata_o        = wdata_q;
  assign reg_wr_en_o        = wr_q;
  assign reg_rd_en_o        = rd_q;
  assign busy_o             = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: RX/TX FIFO and register-bus models,
// expected bus cycles and TX bytes queued per command and checked as they appear.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, tx_full;
  logic       rx_empty, rx_rd, tx_we, wr, rd, busy;
  logic [7:0] rx_data, tx_data, addr, wdata, rdata;
  logic       rx0_empty, rx0_rd, tx0_we, wr0, rd0, busy0;
  logic [7:0] rx0_data, tx0_data, addr0, wdata0, rdata0;

  uart_cmd_parser #(.RESP_CRLF(1'b1)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .rx_fifo_empty_i(rx_empty), .rx_fifo_data_out_i(rx_data), .rx_fifo_read_en_o(rx_rd),
    .tx_fifo_full_i(tx_full), .tx_fifo_data_in_o(tx_data), .tx_fifo_write_en_o(tx_we),
    .reg_addr_o(addr), .reg_wdata_o(wdata), .reg_wr_en_o(wr), .reg_rd_en_o(rd),
    .reg_rdata_i(rdata), .busy_o(busy));

  uart_cmd_parser #(.RESP_CRLF(1'b0)) dut0 (
    .clock_i(clk), .reset_n_i(rst_n),
    .rx_fifo_empty_i(rx0_empty), .rx_fifo_data_out_i(rx0_data), .rx_fifo_read_en_o(rx0_rd),
    .tx_fifo_full_i(tx_full), .tx_fifo_data_in_o(tx0_data), .tx_fifo_write_en_o(tx0_we),
    .reg_addr_o(addr0), .reg_wdata_o(wdata0), .reg_wr_en_o(wr0), .reg_rd_en_o(rd0),
    .reg_rdata_i(rdata0), .busy_o(busy0));

  typedef struct packed {logic is_wr; logic [7:0] a; logic [7:0] d;} bus_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] rx_q[$], exp_tx[$], rx0_q[$], exp0_tx[$];
  bus_t       exp_bus[$];
  bus_t       mon_e;
  logic [7:0] mon_b;
  logic [7:0] rd_val = 8'h00;
  logic       rd_prev = 1'b0;
  logic       lat_chk = 1'b1;
  logic       first_pending = 1'b0;
  int         last_pop = 0, strobe_cyc = 0, first_gap = 0, exp0_wr_cnt = 0;

  // FIFO/register models and the output monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rx_rd) begin
      last_pop = cyc;
      if (rx_q.size() > 0) void'(rx_q.pop_front());
    end
    if (rx0_rd && rx0_q.size() > 0) void'(rx0_q.pop_front());
    rx_empty  = (rx_q.size() == 0);
    rx_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    rx0_empty = (rx0_q.size() == 0);
    rx0_data  = (rx0_q.size() == 0) ? 8'h00 : rx0_q[0];
    rdata     = rd_prev ? rd_val : 8'hEE;
    rd_prev   = rd;
    if (!rst_n) first_pending = 1'b0;

    if (rx_rd || tx_we || wr || rd) begin
      vectors++;
      if ((32'(rx_rd) + 32'(tx_we) + 32'(wr) + 32'(rd)) > 1) begin
        miscompares++;
        $display("FAIL strobe_exclusive: rx_rd=%b tx_we=%b wr=%b rd=%b, required at most one", rx_rd, tx_we, wr, rd);
      end
    end
    if (wr || rd) begin
      vectors++;
      if (exp_bus.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_bus: wr=%b rd=%b addr=%h, required no strobe", wr, rd, addr);
      end else begin
        mon_e = exp_bus.pop_front();
        if (mon_e.is_wr !== wr || mon_e.a !== addr || (wr && mon_e.d !== wdata)) begin
          miscompares++;
          $display("FAIL bus_cmd: got wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                   wr, addr, wdata, mon_e.is_wr, mon_e.a, mon_e.d);
        end
      end
      vectors++;
      if (cyc - last_pop != 2) begin
        miscompares++;
        $display("FAIL bus_latency: got %0d cycles after CR pop, required 2", cyc - last_pop);
      end
      first_pending = 1'b1;
      first_gap     = wr ? 1 : 2;
      strobe_cyc    = cyc;
    end
    if (tx_we) begin
      vectors++;
      if (tx_full) begin
        miscompares++;
        $display("FAIL tx_while_full: got write strobe, required none");
      end
      if (exp_tx.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tx: got byte %h, required none", tx_data);
      end else begin
        mon_b = exp_tx.pop_front();
        if (tx_data !== mon_b) begin
          miscompares++;
          $display("FAIL tx_byte: got %h, required %h", tx_data, mon_b);
        end
      end
      if (first_pending && lat_chk) begin
        vectors++;
        if (cyc - strobe_cyc != first_gap) begin
          miscompares++;
          $display("FAIL first_byte_latency: got %0d, required %0d", cyc - strobe_cyc, first_gap);
        end
      end
      first_pending = 1'b0;
    end
    if (tx0_we) begin
      vectors++;
      if (exp0_tx.size() == 0) begin
        miscompares++;
        $display("FAIL crlf0_unexpected_tx: got byte %h, required none", tx0_data);
      end else begin
        mon_b = exp0_tx.pop_front();
        if (tx0_data !== mon_b) begin
          miscompares++;
          $display("FAIL crlf0_tx_byte: got %h, required %h", tx0_data, mon_b);
        end
      end
    end
    if (wr0 || rd0) begin
      vectors++;
      if (rd0 || exp0_wr_cnt == 0 || addr0 !== 8'h01 || wdata0 !== 8'hFF) begin
        miscompares++;
        $display("FAIL crlf0_bus: got wr=%b rd=%b addr=%h wdata=%h, required wr addr=01 wdata=FF", wr0, rd0, addr0, wdata0);
      end else begin
        exp0_wr_cnt--;
      end
    end
  end

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    rx_q.push_back(8'h0D);
  endtask

  task automatic exp_resp(input string s);
    exp_tx.push_back(s[0]);
    exp_tx.push_back(s[1]);
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
  endtask

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    exp_bus.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [7:0] a);
    exp_bus.push_back({1'b0, a, 8'h00});
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_bus.size() != 0 || busy !== 1'b0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (n >= 600) begin
      miscompares++;
      $display("FAIL %s_timeout: got rx=%0d tx=%0d bus=%0d pending, required 0", name, rx_q.size(), exp_tx.size(), exp_bus.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_full = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({rx_rd, tx_we, wr, rd, busy} !== 5'b0 || tx_data !== 8'h00 || addr !== 8'h00 || wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got strobes=%b tx=%h addr=%h wdata=%h, required all 0",
               {rx_rd, tx_we, wr, rd, busy}, tx_data, addr, wdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    send_line("W3C5A");
    exp_wr(8'h3C, 8'h5A);
    exp_resp("OK");
    wait_done("write");
  endtask

  task automatic test_read();
    rd_val = 8'hA7;
    send_line("r3c");
    exp_rd(8'h3C);
    exp_resp("A7");
    wait_done("read");
  endtask

  task automatic test_errors();
    send_line("W3G5A");  exp_resp("ER");
    send_line("X12");    exp_resp("ER");
    send_line("");       exp_resp("ER");
    send_line("W123456"); exp_resp("ER");
    send_line("R1");     exp_resp("ER");
    wait_done("errors");
    vectors++;
    if (addr !== 8'h3C || wdata !== 8'h5A) begin
      miscompares++;
      $display("FAIL bus_hold: got addr=%h wdata=%h, required 3c 5a", addr, wdata);
    end
  endtask

  task automatic test_lowercase_write();
    send_line("w0aFf");
    exp_wr(8'h0A, 8'hFF);
    exp_resp("OK");
    wait_done("lowercase");
  endtask

  task automatic test_lf();
    rd_val = 8'h3F;
    rx_q.push_back(8'h52); rx_q.push_back(8'h0A);
    rx_q.push_back(8'h31); rx_q.push_back(8'h0A);
    rx_q.push_back(8'h30); rx_q.push_back(8'h0D);
    exp_rd(8'h10);
    exp_resp("3F");
    wait_done("lf_skip");
  endtask

  task automatic test_backpressure();
    int n = 0;
    lat_chk = 1'b0;
    tx_full = 1'b1;
    send_line("W1122");
    exp_wr(8'h11, 8'h22);
    exp_resp("OK");
    while (exp_bus.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    vectors++;
    if (exp_tx.size() != 4 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_stall: got %0d bytes pending busy=%b, required 4 pending busy=1", exp_tx.size(), busy);
    end
    tx_full = 1'b0;
    wait_done("backpressure");
    lat_chk = 1'b1;
  endtask

  task automatic test_back_to_back();
    rd_val = 8'h5C;
    send_line("W0102");
    send_line("R01");
    send_line("Z");
    exp_wr(8'h01, 8'h02); exp_resp("OK");
    exp_rd(8'h01);        exp_resp("5C");
    exp_resp("ER");
    wait_done("back_to_back");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rx_q.push_back(8'h57); rx_q.push_back(8'h31); rx_q.push_back(8'h32);
    while (rx_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_val = 8'h9B;
    send_line("R12");
    exp_rd(8'h12);
    exp_resp("9B");
    wait_done("reset_mid_cmd");
    // Abandon a stalled response: the write happens, no TX byte may follow.
    n = 0;
    tx_full = 1'b1;
    send_line("W4455");
    exp_wr(8'h44, 8'h55);
    while (exp_bus.size() != 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_full = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || exp_bus.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_resp: got busy=%b bus_pending=%0d, required 0 0", busy, exp_bus.size());
    end
  endtask

  task automatic test_cr_only_term();
    int n = 0;
    rx0_q.push_back(8'h57); rx0_q.push_back(8'h30); rx0_q.push_back(8'h31);
    rx0_q.push_back(8'h46); rx0_q.push_back(8'h66); rx0_q.push_back(8'h0D);
    exp0_tx.push_back(8'h4F); exp0_tx.push_back(8'h4B); exp0_tx.push_back(8'h0D);
    exp0_wr_cnt = 1;
    while ((rx0_q.size() != 0 || exp0_tx.size() != 0 || busy0 !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (n >= 300 || exp0_wr_cnt != 0) begin
      miscompares++;
      $display("FAIL crlf0_done: got tx_pending=%0d wr_pending=%0d, required 0 0", exp0_tx.size(), exp0_wr_cnt);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tx_full   = 1'b0;
    rx_empty  = 1'b1;
    rx_data   = 8'h00;
    rx0_empty = 1'b1;
    rx0_data  = 8'h00;
    rdata     = 8'hEE;
    rdata0    = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_lowercase_write();
    test_lf();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_cr_only_term();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
